// File: rtl/switch_mcu_inst_decoder.sv
// ---------------------------------------------------------------------------
// switch_mcu_inst_decoder
//
// Purpose:
//   RV32I instruction decoder for the switch MCU execute stage. It takes one
//   32-bit instruction word and turns it into a set of one-hot instruction
//   strobes, the three register indices and the raw immediate fields. Every
//   output is registered. The registers load only on a rising clock edge where
//   the shared execution phase counter reads 0. At any other count, including
//   the unused values 3..15, they hold their value.
//
// Ports:
//   in_clk            clock, rising edge
//   in_rst            asynchronous active-high reset, clears every output
//   in_cycle_cnt[3:0] execution phase (0,1,2 repeating); capture in phase 0
//   in_inst[31:0]     instruction word to decode
//   out_<mnemonic>    one strobe per RV32I instruction, at most one high
//   out_rs1/rs2/rd    inst[19:15] / inst[24:20] / inst[11:7]
//   out_imm_type_i    inst[31:20]
//   out_imm_type_s    {inst[31:25], inst[11:7]}
//   out_imm_type_b    imm[12:1]
//   out_imm_type_u    inst[31:12]
//   out_imm_type_j    imm[20:2] (imm[1] dropped, jump targets are word aligned)
//
// There is no handshake. Phase 0 of the counter acts as the load enable.
// Unrecognised encodings decode to all strobes low, and no exception is raised.
// ---------------------------------------------------------------------------
module switch_mcu_inst_decoder (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic [3:0]  in_cycle_cnt,
    input  logic [31:0] in_inst,
    output logic        out_lui,
    output logic        out_auipc,
    output logic        out_jal,
    output logic        out_jalr,
    output logic        out_beq,
    output logic        out_bne,
    output logic        out_blt,
    output logic        out_bge,
    output logic        out_bltu,
    output logic        out_bgeu,
    output logic        out_lb,
    output logic        out_lh,
    output logic        out_lw,
    output logic        out_lbu,
    output logic        out_lhu,
    output logic        out_sb,
    output logic        out_sh,
    output logic        out_sw,
    output logic        out_addi,
    output logic        out_slti,
    output logic        out_sltiu,
    output logic        out_xori,
    output logic        out_ori,
    output logic        out_andi,
    output logic        out_slli,
    output logic        out_srli,
    output logic        out_srai,
    output logic        out_add,
    output logic        out_sub,
    output logic        out_sll,
    output logic        out_slt,
    output logic        out_sltu,
    output logic        out_xor,
    output logic        out_srl,
    output logic        out_sra,
    output logic        out_or,
    output logic        out_and,
    output logic        out_fence,
    output logic        out_fence_i,
    output logic        out_ecall,
    output logic        out_ebreak,
    output logic        out_csrrw,
    output logic        out_csrrs,
    output logic        out_csrrc,
    output logic        out_csrrwi,
    output logic        out_csrrsi,
    output logic        out_csrrci,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rd,
    output logic [11:0] out_imm_type_i,
    output logic [11:0] out_imm_type_s,
    output logic [11:0] out_imm_type_b,
    output logic [19:0] out_imm_type_u,
    output logic [18:0] out_imm_type_j
);

    // All strobes in one packed struct, so that clearing and loading them is a
    // single assignment. The and/or/xor members carry a suffix because the
    // bare words are SystemVerilog keywords.
    typedef struct packed {
        logic lui, auipc, jal, jalr;
        logic beq, bne, blt, bge, bltu, bgeu;
        logic lb, lh, lw, lbu, lhu, sb, sh, sw;
        logic addi, slti, sltiu, xori, ori, andi, slli, srli, srai;
        logic add, sub, sll, slt, sltu, xor_op, srl, sra, or_op, and_op;
        logic fence, fence_i, ecall, ebreak;
        logic csrrw, csrrs, csrrc, csrrwi, csrrsi, csrrci;
    } strobes_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    strobes_t   dec;
    strobes_t   dec_q;
    logic       capture;

    assign opcode  = in_inst[6:0];
    assign f3      = in_inst[14:12];
    assign f7      = in_inst[31:25];
    // Counter values above 2 never come from the slot sequencer. They fall
    // through to hold along with phases 1 and 2.
    assign capture = (in_cycle_cnt == 4'd0);

    always_comb begin
        dec = '0;
        case (opcode)
            OPC_LUI:   dec.lui   = 1'b1;
            OPC_AUIPC: dec.auipc = 1'b1;
            OPC_JAL:   dec.jal   = 1'b1;
            OPC_JALR:  dec.jalr  = (f3 == 3'b000);
            OPC_BRANCH: begin
                case (f3)
                    3'b000:  dec.beq  = 1'b1;
                    3'b001:  dec.bne  = 1'b1;
                    3'b100:  dec.blt  = 1'b1;
                    3'b101:  dec.bge  = 1'b1;
                    3'b110:  dec.bltu = 1'b1;
                    3'b111:  dec.bgeu = 1'b1;
                    default: ;
                endcase
            end
            OPC_LOAD: begin
                case (f3)
                    3'b000:  dec.lb  = 1'b1;
                    3'b001:  dec.lh  = 1'b1;
                    3'b010:  dec.lw  = 1'b1;
                    3'b100:  dec.lbu = 1'b1;
                    3'b101:  dec.lhu = 1'b1;
                    default: ;
                endcase
            end
            OPC_STORE: begin
                case (f3)
                    3'b000:  dec.sb = 1'b1;
                    3'b001:  dec.sh = 1'b1;
                    3'b010:  dec.sw = 1'b1;
                    default: ;
                endcase
            end
            OPC_OPIMM: begin
                // Only the shift-immediate forms look at funct7, because bits
                // 31:25 are ordinary immediate bits for the others.
                case (f3)
                    3'b000:  dec.addi  = 1'b1;
                    3'b010:  dec.slti  = 1'b1;
                    3'b011:  dec.sltiu = 1'b1;
                    3'b100:  dec.xori  = 1'b1;
                    3'b110:  dec.ori   = 1'b1;
                    3'b111:  dec.andi  = 1'b1;
                    3'b001:  dec.slli  = (f7 == F7_BASE);
                    3'b101: begin
                        dec.srli = (f7 == F7_BASE);
                        dec.srai = (f7 == F7_ALT);
                    end
                    default: ;
                endcase
            end
            OPC_OP: begin
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000:  dec.add    = 1'b1;
                        3'b001:  dec.sll    = 1'b1;
                        3'b010:  dec.slt    = 1'b1;
                        3'b011:  dec.sltu   = 1'b1;
                        3'b100:  dec.xor_op = 1'b1;
                        3'b101:  dec.srl    = 1'b1;
                        3'b110:  dec.or_op  = 1'b1;
                        default: dec.and_op = 1'b1;
                    endcase
                end else if (f7 == F7_ALT) begin
                    dec.sub = (f3 == 3'b000);
                    dec.sra = (f3 == 3'b101);
                end
            end
            OPC_FENCE: begin
                dec.fence   = (f3 == 3'b000);
                dec.fence_i = (f3 == 3'b001);
            end
            OPC_SYSTEM: begin
                // ecall and ebreak are matched on the whole word. Any other
                // funct3=000 SYSTEM word (e.g. mret/wfi) decodes to nothing.
                if (in_inst == 32'h0000_0073) begin
                    dec.ecall = 1'b1;
                end else if (in_inst == 32'h0010_0073) begin
                    dec.ebreak = 1'b1;
                end else begin
                    case (f3)
                        3'b001:  dec.csrrw  = 1'b1;
                        3'b010:  dec.csrrs  = 1'b1;
                        3'b011:  dec.csrrc  = 1'b1;
                        3'b101:  dec.csrrwi = 1'b1;
                        3'b110:  dec.csrrsi = 1'b1;
                        3'b111:  dec.csrrci = 1'b1;
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            dec_q          <= '0;
            out_rs2        <= '0;
            out_rs1        <= '0;
            out_rd         <= '0;
            out_imm_type_i <= '0;
            out_imm_type_s <= '0;
            out_imm_type_b <= '0;
            out_imm_type_u <= '0;
            out_imm_type_j <= '0;
        end else if (capture) begin
            dec_q          <= dec;
            out_rs2        <= in_inst[24:20];
            out_rs1        <= in_inst[19:15];
            out_rd         <= in_inst[11:7];
            out_imm_type_i <= in_inst[31:20];
            out_imm_type_s <= {in_inst[31:25], in_inst[11:7]};
            out_imm_type_b <= {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8]};
            out_imm_type_u <= in_inst[31:12];
            out_imm_type_j <= {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:22]};
        end
    end

    assign out_lui     = dec_q.lui;
    assign out_auipc   = dec_q.auipc;
    assign out_jal     = dec_q.jal;
    assign out_jalr    = dec_q.jalr;
    assign out_beq     = dec_q.beq;
    assign out_bne     = dec_q.bne;
    assign out_blt     = dec_q.blt;
    assign out_bge     = dec_q.bge;
    assign out_bltu    = dec_q.bltu;
    assign out_bgeu    = dec_q.bgeu;
    assign out_lb      = dec_q.lb;
    assign out_lh      = dec_q.lh;
    assign out_lw      = dec_q.lw;
    assign out_lbu     = dec_q.lbu;
    assign out_lhu     = dec_q.lhu;
    assign out_sb      = dec_q.sb;
    assign out_sh      = dec_q.sh;
    assign out_sw      = dec_q.sw;
    assign out_addi    = dec_q.addi;
    assign out_slti    = dec_q.slti;
    assign out_sltiu   = dec_q.sltiu;
    assign out_xori    = dec_q.xori;
    assign out_ori     = dec_q.ori;
    assign out_andi    = dec_q.andi;
    assign out_slli    = dec_q.slli;
    assign out_srli    = dec_q.srli;
    assign out_srai    = dec_q.srai;
    assign out_add     = dec_q.add;
    assign out_sub     = dec_q.sub;
    assign out_sll     = dec_q.sll;
    assign out_slt     = dec_q.slt;
    assign out_sltu    = dec_q.sltu;
    assign out_xor     = dec_q.xor_op;
    assign out_srl     = dec_q.srl;
    assign out_sra     = dec_q.sra;
    assign out_or      = dec_q.or_op;
    assign out_and     = dec_q.and_op;
    assign out_fence   = dec_q.fence;
    assign out_fence_i = dec_q.fence_i;
    assign out_ecall   = dec_q.ecall;
    assign out_ebreak  = dec_q.ebreak;
    assign out_csrrw   = dec_q.csrrw;
    assign out_csrrs   = dec_q.csrrs;
    assign out_csrrc   = dec_q.csrrc;
    assign out_csrrwi  = dec_q.csrrwi;
    assign out_csrrsi  = dec_q.csrrsi;
    assign out_csrrci  = dec_q.csrrci;

endmodule

// File: tb/tb_switch_mcu_inst_decoder.sv
// ---------------------------------------------------------------------------
// tb_switch_mcu_inst_decoder
//
// Directed bench for the RV32I decoder. Each stimulus step pushes the full
// expected output word (strobes followed by fields) onto exp_q. After the
// capturing edge the bench pops that word and compares it with the DUT
// outputs. Strobe order, MSB first, follows the port list: lui = position 0,
// csrrci = position 46.
// ---------------------------------------------------------------------------
module tb_switch_mcu_inst_decoder;

  localparam int W  = 137;  // 47 strobes + 3*5 regs + 3*12 + 20 + 19 imm bits
  localparam int NS = 47;

  logic        clk;
  logic        rst;
  logic [3:0]  cnt;
  logic [31:0] inst;

  logic s_lui, s_auipc, s_jal, s_jalr, s_beq, s_bne, s_blt, s_bge, s_bltu, s_bgeu;
  logic s_lb, s_lh, s_lw, s_lbu, s_lhu, s_sb, s_sh, s_sw;
  logic s_addi, s_slti, s_sltiu, s_xori, s_ori, s_andi, s_slli, s_srli, s_srai;
  logic s_add, s_sub, s_sll, s_slt, s_sltu, s_xor, s_srl, s_sra, s_or, s_and;
  logic s_fence, s_fence_i, s_ecall, s_ebreak;
  logic s_csrrw, s_csrrs, s_csrrc, s_csrrwi, s_csrrsi, s_csrrci;
  logic [4:0]  rs2, rs1, rd;
  logic [11:0] imm_i, imm_s, imm_b;
  logic [19:0] imm_u;
  logic [18:0] imm_j;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] held;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] inst;
    int          pos;   // expected strobe position, -1 = none
  } vec_t;

  switch_mcu_inst_decoder dut (
    .in_clk(clk), .in_rst(rst), .in_cycle_cnt(cnt), .in_inst(inst),
    .out_lui(s_lui), .out_auipc(s_auipc), .out_jal(s_jal), .out_jalr(s_jalr),
    .out_beq(s_beq), .out_bne(s_bne), .out_blt(s_blt), .out_bge(s_bge),
    .out_bltu(s_bltu), .out_bgeu(s_bgeu),
    .out_lb(s_lb), .out_lh(s_lh), .out_lw(s_lw), .out_lbu(s_lbu), .out_lhu(s_lhu),
    .out_sb(s_sb), .out_sh(s_sh), .out_sw(s_sw),
    .out_addi(s_addi), .out_slti(s_slti), .out_sltiu(s_sltiu), .out_xori(s_xori),
    .out_ori(s_ori), .out_andi(s_andi), .out_slli(s_slli), .out_srli(s_srli),
    .out_srai(s_srai),
    .out_add(s_add), .out_sub(s_sub), .out_sll(s_sll), .out_slt(s_slt),
    .out_sltu(s_sltu), .out_xor(s_xor), .out_srl(s_srl), .out_sra(s_sra),
    .out_or(s_or), .out_and(s_and),
    .out_fence(s_fence), .out_fence_i(s_fence_i), .out_ecall(s_ecall),
    .out_ebreak(s_ebreak),
    .out_csrrw(s_csrrw), .out_csrrs(s_csrrs), .out_csrrc(s_csrrc),
    .out_csrrwi(s_csrrwi), .out_csrrsi(s_csrrsi), .out_csrrci(s_csrrci),
    .out_rs2(rs2), .out_rs1(rs1), .out_rd(rd),
    .out_imm_type_i(imm_i), .out_imm_type_s(imm_s), .out_imm_type_b(imm_b),
    .out_imm_type_u(imm_u), .out_imm_type_j(imm_j)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] observed();
    return {s_lui, s_auipc, s_jal, s_jalr, s_beq, s_bne, s_blt, s_bge, s_bltu, s_bgeu,
            s_lb, s_lh, s_lw, s_lbu, s_lhu, s_sb, s_sh, s_sw,
            s_addi, s_slti, s_sltiu, s_xori, s_ori, s_andi, s_slli, s_srli, s_srai,
            s_add, s_sub, s_sll, s_slt, s_sltu, s_xor, s_srl, s_sra, s_or, s_and,
            s_fence, s_fence_i, s_ecall, s_ebreak,
            s_csrrw, s_csrrs, s_csrrc, s_csrrwi, s_csrrsi, s_csrrci,
            rd, rs1, rs2, imm_i, imm_s, imm_b, imm_u, imm_j};
  endfunction

  // Expected word: one-hot strobe at the given position plus the raw fields
  // of the instruction.
  function automatic logic [W-1:0] expect_word(input logic [31:0] i, input int pos);
    logic [NS-1:0] st;
    st = '0;
    if (pos >= 0) st[NS-1-pos] = 1'b1;
    return {st, i[11:7], i[19:15], i[24:20], i[31:20],
            i[31:25], i[11:7],
            i[31], i[7], i[30:25], i[11:8],
            i[31:12],
            i[31], i[19:12], i[20], i[30:22]};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_small(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: one full 3-phase slot. Capture inst in phase 0, then present
  // hold_inst during phases 1 and 2 and expect the outputs to keep still.
  task automatic issue(input logic [31:0] i, input int pos, input logic [31:0] hold_inst);
    logic [W-1:0] e;
    @(negedge clk);
    inst = i;
    cnt  = 4'd0;
    exp_q.push_back(expect_word(i, pos));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check($sformatf("capture_%h", i), observed(), e);
    held = e;
    for (int p = 1; p <= 2; p++) begin
      @(negedge clk);
      cnt  = p[3:0];
      inst = hold_inst;
      @(posedge clk);
      #1;
      check($sformatf("hold_p%0d_%h", p, i), observed(), held);
    end
  endtask

  vec_t vecs[$];

  initial begin
    rst  = 1'b1;
    cnt  = 4'd0;
    inst = 32'hAAAA_A0B7;

    // reset with a lui pending at cnt=0: stays cleared through edges
    #1;
    check("reset_async", observed(), '0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("reset_edge%0d", k), observed(), '0);
    end
    @(negedge clk);
    rst = 1'b0;

    // lui followed by auipc, whose word is driven during the hold phases
    vecs.push_back('{32'hAAAA_A0B7, 0});
    vecs.push_back('{32'hAAAA_A117, 1});
    vecs.push_back('{32'h0000_0000, -1});
    vecs.push_back('{32'h4020_8033, 28});   // sub x0,x1,x2
    vecs.push_back('{32'h0020_8033, 27});   // add
    vecs.push_back('{32'h0010_0073, 40});   // ebreak
    vecs.push_back('{32'hFE00_0EE3, 4});    // beq, imm -4
    vecs.push_back('{32'h0000_0073, 39});   // ecall
    vecs.push_back('{32'h0000_006F, 2});    // jal
    vecs.push_back('{32'h0000_80E7, 3});    // jalr
    vecs.push_back('{32'h0000_1067, -1});   // jalr bad f3
    vecs.push_back('{32'h0000_1063, 5});
    vecs.push_back('{32'h0000_4063, 6});
    vecs.push_back('{32'h0000_5063, 7});
    vecs.push_back('{32'h0000_6063, 8});
    vecs.push_back('{32'h0000_7063, 9});
    vecs.push_back('{32'h0000_2063, -1});
    vecs.push_back('{32'h0000_0003, 10});
    vecs.push_back('{32'h0000_1003, 11});
    vecs.push_back('{32'h0000_2003, 12});
    vecs.push_back('{32'h0000_4003, 13});
    vecs.push_back('{32'h0000_5003, 14});
    vecs.push_back('{32'h0000_3003, -1});
    vecs.push_back('{32'h0000_0023, 15});
    vecs.push_back('{32'h0000_1023, 16});
    vecs.push_back('{32'h0000_2023, 17});
    vecs.push_back('{32'h0000_3023, -1});
    vecs.push_back('{32'hFFF0_0013, 18});   // addi with all-ones immediate
    vecs.push_back('{32'h0000_2013, 19});
    vecs.push_back('{32'h0000_3013, 20});
    vecs.push_back('{32'h0000_4013, 21});
    vecs.push_back('{32'h0000_6013, 22});
    vecs.push_back('{32'h0000_7013, 23});
    vecs.push_back('{32'h0000_1013, 24});
    vecs.push_back('{32'h0000_5013, 25});
    vecs.push_back('{32'h4000_5013, 26});
    vecs.push_back('{32'h0200_1013, -1});   // slli with bad f7
    vecs.push_back('{32'h0000_1033, 29});
    vecs.push_back('{32'h0000_2033, 30});
    vecs.push_back('{32'h0000_3033, 31});
    vecs.push_back('{32'h0000_4033, 32});
    vecs.push_back('{32'h0000_5033, 33});
    vecs.push_back('{32'h4000_5033, 34});
    vecs.push_back('{32'h0000_6033, 35});
    vecs.push_back('{32'h0000_7033, 36});
    vecs.push_back('{32'h4000_1033, -1});
    vecs.push_back('{32'h0200_0033, -1});   // mul: not RV32I
    vecs.push_back('{32'h0000_000F, 37});
    vecs.push_back('{32'h0000_100F, 38});
    vecs.push_back('{32'h0000_200F, -1});
    vecs.push_back('{32'h0000_1073, 41});
    vecs.push_back('{32'h0000_2073, 42});
    vecs.push_back('{32'h0000_3073, 43});
    vecs.push_back('{32'h0000_5073, 44});
    vecs.push_back('{32'h0000_6073, 45});
    vecs.push_back('{32'h0000_7073, 46});
    vecs.push_back('{32'h0000_4073, -1});
    vecs.push_back('{32'h0020_0073, -1});   // SYSTEM f3=000, neither ecall nor ebreak

    for (int v = 0; v < vecs.size(); v++) begin
      logic [31:0] nxt;
      nxt = (v + 1 < vecs.size()) ? vecs[v+1].inst : $urandom();
      issue(vecs[v].inst, vecs[v].pos, nxt);
      // hand-derived values for the documented examples
      if (vecs[v].inst == 32'hAAAA_A0B7) begin
        check_small("lui_strobe", {31'd0, s_lui}, 32'd1);
        check_small("lui_rd", {27'd0, rd}, 32'd1);
        check_small("lui_imm_u", {12'd0, imm_u}, 32'h000A_AAAA);
      end
      if (vecs[v].inst == 32'hAAAA_A117) begin
        check_small("auipc_strobe", {31'd0, s_auipc}, 32'd1);
        check_small("auipc_rd", {27'd0, rd}, 32'd2);
      end
      if (vecs[v].inst == 32'h4020_8033) begin
        check_small("sub_rs1", {27'd0, rs1}, 32'd1);
        check_small("sub_rs2", {27'd0, rs2}, 32'd2);
      end
      if (vecs[v].inst == 32'hFE00_0EE3)
        check_small("beq_imm_b", {20'd0, imm_b}, 32'h0000_0FFE);
    end

    // random fields through an addi capture, counter values 3..15 must hold
    begin
      logic [31:0] r;
      r = {$urandom_range(0, 32'hFFFF_FFFF)} & 32'hFFFF_8FFF;
      r = (r & ~32'h0000_707F) | 32'h0000_0013;
      issue(r, 18, $urandom());
      for (int c = 3; c < 16; c++) begin
        @(negedge clk);
        cnt  = c[3:0];
        inst = 32'hAAAA_A0B7;
        @(posedge clk);
        #1;
        check($sformatf("hold_cnt%0d", c), observed(), held);
      end
    end

    // reset asserted mid-slot clears at once and suppresses a phase-0 edge
    issue(32'h0020_8033, 27, 32'h0000_0000);
    @(negedge clk);
    cnt = 4'd0;
    inst = 32'h0000_006F;
    #2;
    rst = 1'b1;
    #1;
    check("midslot_reset", observed(), '0);
    @(posedge clk);
    #1;
    check("reset_at_cnt0", observed(), '0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 4'd1;
    @(posedge clk);
    #1;
    check("post_reset_p1", observed(), '0);
    @(negedge clk);
    cnt = 4'd2;
    @(posedge clk);
    #1;
    check("post_reset_p2", observed(), '0);
    issue(32'h0000_006F, 2, 32'h0000_0000);

    check_small("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
